// File: rtl/regfile_wr_arb_if.sv
// Write-request / regfile-port bundle for regfile_wr_arb.
// master = requester side (plus regfile observer), slave = the arbiter.
interface regfile_wr_arb_if #(parameter int NREQ = 4);
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [3*NREQ-1:0]    req_reg;
  logic [4*NREQ-1:0]    req_strb;
  logic [32*NREQ-1:0]   req_data;
  logic                 wr_en1, wr_en2, wr_en3;
  logic [2:0]           wr_reg1, wr_reg2, wr_reg3;
  logic [3:0]           wr_strb1, wr_strb2, wr_strb3;
  logic [31:0]          wr_data1, wr_data2, wr_data3;
  logic [31:0]          pend_byte;

  modport master (
    output req_valid, req_reg, req_strb, req_data,
    input  req_ready, wr_en1, wr_en2, wr_en3, wr_reg1, wr_reg2, wr_reg3,
           wr_strb1, wr_strb2, wr_strb3, wr_data1, wr_data2, wr_data3, pend_byte
  );

  modport slave (
    input  req_valid, req_reg, req_strb, req_data,
    output req_ready, wr_en1, wr_en2, wr_en3, wr_reg1, wr_reg2, wr_reg3,
           wr_strb1, wr_strb2, wr_strb3, wr_data1, wr_data2, wr_data3, pend_byte
  );
endinterface

// File: rtl/regfile_wr_arb.sv
// Register-file write-port scheduler: one buffer per requester, rotating-priority
// grant of up to three non-conflicting writes per cycle onto registered ports,
// plus a pending-byte scoreboard for decode.
module regfile_wr_arb #(
  parameter int NREQ = 4
) (
  input logic             clk,
  input logic             rst,
  input logic             flush,
  regfile_wr_arb_if.slave bus
);
  localparam int PW = (NREQ > 2) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0]        buf_v, grant, hs, ready;
  logic [NREQ-1:0][2:0]   buf_reg;
  logic [NREQ-1:0][3:0]   buf_strb;
  logic [NREQ-1:0][31:0]  buf_data;
  logic [PW-1:0]          rr_ptr, rr_next, idx;
  logic                   any_grant, clash;
  logic [1:0]             n;
  logic [2:0]             p_v;
  logic [2:0][PW-1:0]     p_idx;
  logic [2:0]             en_q;
  logic [2:0][2:0]        reg_q;
  logic [2:0][3:0]        strb_q;
  logic [2:0][31:0]       data_q;
  logic [31:0]            pend;

  // A buffer can take a new write when empty or when it is being drained this cycle.
  assign ready         = {NREQ{!rst && !flush}} & (~buf_v | grant);
  assign hs            = bus.req_valid & ready;
  assign bus.req_ready = ready;

  // Rotating scan from rr_ptr; each entry takes the next free port unless it
  // collides on a byte with a write already granted this cycle.
  always_comb begin
    grant     = '0;
    p_v       = '0;
    p_idx     = '0;
    any_grant = 1'b0;
    rr_next   = rr_ptr;
    n         = 2'd0;
    idx       = '0;
    clash     = 1'b0;
    for (int s = 0; s < NREQ; s++) begin
      idx = PW'((int'(rr_ptr) + s) % NREQ);
      if (!rst && !flush && buf_v[idx] && n < 2'd3) begin
        clash = 1'b0;
        for (int k = 0; k < 3; k++)
          if (p_v[k] && buf_reg[p_idx[k]] == buf_reg[idx] &&
              |(buf_strb[p_idx[k]] & buf_strb[idx]))
            clash = 1'b1;
        if (!clash) begin
          grant[idx] = 1'b1;
          p_v[n]     = 1'b1;
          p_idx[n]   = idx;
          if (!any_grant) rr_next = PW'((int'(idx) + 1) % NREQ);
          any_grant  = 1'b1;
          n          = n + 2'd1;
        end
      end
    end
  end

  // Per-requester buffers: load on handshake (zero-strobe writes are dropped), free on grant.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NREQ; i++) begin
      if (rst || flush) begin
        buf_v[i] <= 1'b0;
      end else if (hs[i]) begin
        buf_v[i] <= |bus.req_strb[4*i +: 4];
        if (|bus.req_strb[4*i +: 4]) begin
          buf_reg[i]  <= bus.req_reg[3*i +: 3];
          buf_strb[i] <= bus.req_strb[4*i +: 4];
          buf_data[i] <= bus.req_data[32*i +: 32];
        end
      end else if (grant[i]) begin
        buf_v[i] <= 1'b0;
      end
    end
  end

  // Rotate priority to just past the first entry granted this cycle.
  always_ff @(posedge clk) begin
    if (rst)            rr_ptr <= '0;
    else if (any_grant) rr_ptr <= rr_next;
  end

  // Registered write ports; an idle port drops its enable but keeps its fields.
  always_ff @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (rst) begin
        en_q[k]   <= 1'b0;
        reg_q[k]  <= '0;
        strb_q[k] <= '0;
        data_q[k] <= '0;
      end else begin
        en_q[k] <= p_v[k];
        if (p_v[k]) begin
          reg_q[k]  <= buf_reg[p_idx[k]];
          strb_q[k] <= buf_strb[p_idx[k]];
          data_q[k] <= buf_data[p_idx[k]];
        end
      end
    end
  end

  // Scoreboard: bytes held in buffers or on an enabled port are not yet committed.
  always_comb begin
    pend = '0;
    for (int i = 0; i < NREQ; i++)
      if (buf_v[i]) pend[{buf_reg[i], 2'b00} +: 4] = pend[{buf_reg[i], 2'b00} +: 4] | buf_strb[i];
    for (int k = 0; k < 3; k++)
      if (en_q[k]) pend[{reg_q[k], 2'b00} +: 4] = pend[{reg_q[k], 2'b00} +: 4] | strb_q[k];
  end

  assign bus.pend_byte = pend;
  assign bus.wr_en1    = en_q[0];
  assign bus.wr_en2    = en_q[1];
  assign bus.wr_en3    = en_q[2];
  assign bus.wr_reg1   = reg_q[0];
  assign bus.wr_reg2   = reg_q[1];
  assign bus.wr_reg3   = reg_q[2];
  assign bus.wr_strb1  = strb_q[0];
  assign bus.wr_strb2  = strb_q[1];
  assign bus.wr_strb3  = strb_q[2];
  assign bus.wr_data1  = data_q[0];
  assign bus.wr_data2  = data_q[1];
  assign bus.wr_data3  = data_q[2];
endmodule

// File: tb/tb_regfile_wr_arb.sv
// Directed bench for regfile_wr_arb: latency, rotation, byte conflicts,
// streaming, flush and reset, with hand-computed expectations.
module tb_regfile_wr_arb;
  localparam int NREQ = 4;

  logic clk = 1'b0;
  logic rst, flush;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  regfile_wr_arb_if #(.NREQ(NREQ)) bus();
  regfile_wr_arb #(.NREQ(NREQ)) dut (.clk(clk), .rst(rst), .flush(flush), .bus(bus));

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic set_req(input int i, input logic [2:0] r, input logic [3:0] s, input logic [31:0] d);
    bus.req_valid[i]       = 1'b1;
    bus.req_reg[3*i +: 3]  = r;
    bus.req_strb[4*i +: 4] = s;
    bus.req_data[32*i +: 32] = d;
  endtask

  task automatic clr_req();
    bus.req_valid = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1; flush = 1'b0; clr_req();
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; clr_req();
    bus.req_reg = '0; bus.req_strb = '0; bus.req_data = '0;
    tick(); tick();
    set_req(0, 3'd1, 4'hF, 32'h1);
    #1;
    n_cmp++; if (bus.req_ready !== 4'b0) begin n_bad++; $display("FAIL reset_ready got %b exp 0000", bus.req_ready); end
    n_cmp++; if ({bus.wr_en1, bus.wr_en2, bus.wr_en3} !== 3'b0) begin n_bad++; $display("FAIL reset_en got %b exp 000", {bus.wr_en1, bus.wr_en2, bus.wr_en3}); end
    n_cmp++; if ({bus.wr_reg1, bus.wr_strb1, bus.wr_data1} !== 39'h0) begin n_bad++; $display("FAIL reset_port1 got %h exp 0", {bus.wr_reg1, bus.wr_strb1, bus.wr_data1}); end
    n_cmp++; if (bus.pend_byte !== 32'h0) begin n_bad++; $display("FAIL reset_pend got %h exp 0", bus.pend_byte); end
    clr_req();
    rst = 1'b0;
  endtask

  task automatic test_single();
    set_req(0, 3'd3, 4'hF, 32'hDEADBEEF);
    #1;
    n_cmp++; if (bus.req_ready[0] !== 1'b1) begin n_bad++; $display("FAIL single_ready got %b exp 1", bus.req_ready[0]); end
    tick(); clr_req(); #1;
    n_cmp++; if (bus.pend_byte !== 32'h0000F000) begin n_bad++; $display("FAIL single_pend_c2 got %h exp 0000f000", bus.pend_byte); end
    n_cmp++; if (bus.wr_en1 !== 1'b0) begin n_bad++; $display("FAIL single_en_c2 got %b exp 0", bus.wr_en1); end
    tick(); #1;
    n_cmp++; if ({bus.wr_en1, bus.wr_reg1, bus.wr_strb1, bus.wr_data1} !== {1'b1, 3'd3, 4'hF, 32'hDEADBEEF})
      begin n_bad++; $display("FAIL single_port1 got %b/%0d/%h/%h exp 1/3/f/deadbeef", bus.wr_en1, bus.wr_reg1, bus.wr_strb1, bus.wr_data1); end
    n_cmp++; if (bus.pend_byte !== 32'h0000F000) begin n_bad++; $display("FAIL single_pend_c3 got %h exp 0000f000", bus.pend_byte); end
    tick(); #1;
    n_cmp++; if (bus.wr_en1 !== 1'b0) begin n_bad++; $display("FAIL single_en_c4 got %b exp 0", bus.wr_en1); end
    n_cmp++; if (bus.pend_byte !== 32'h0) begin n_bad++; $display("FAIL single_pend_c4 got %h exp 0", bus.pend_byte); end
  endtask

  task automatic test_zero_strb();
    set_req(1, 3'd2, 4'h0, 32'h55);
    #1;
    n_cmp++; if (bus.req_ready[1] !== 1'b1) begin n_bad++; $display("FAIL zstrb_ready got %b exp 1", bus.req_ready[1]); end
    tick(); clr_req(); #1;
    n_cmp++; if (bus.pend_byte !== 32'h0) begin n_bad++; $display("FAIL zstrb_pend got %h exp 0", bus.pend_byte); end
    tick(); #1;
    n_cmp++; if ({bus.wr_en1, bus.wr_en2, bus.wr_en3} !== 3'b0) begin n_bad++; $display("FAIL zstrb_en got %b exp 000", {bus.wr_en1, bus.wr_en2, bus.wr_en3}); end
  endtask

  task automatic test_round_robin();
    do_reset();
    for (int i = 0; i < NREQ; i++) set_req(i, 3'(i), 4'hF, 32'd100 + 32'(i));
    tick(); clr_req(); #1;
    n_cmp++; if (bus.pend_byte !== 32'h0000FFFF) begin n_bad++; $display("FAIL rr_pend_buf got %h exp 0000ffff", bus.pend_byte); end
    tick(); #1;
    n_cmp++; if ({bus.wr_en1, bus.wr_en2, bus.wr_en3} !== 3'b111) begin n_bad++; $display("FAIL rr_en3 got %b exp 111", {bus.wr_en1, bus.wr_en2, bus.wr_en3}); end
    n_cmp++; if ({bus.wr_reg1, bus.wr_reg2, bus.wr_reg3} !== {3'd0, 3'd1, 3'd2}) begin n_bad++; $display("FAIL rr_regs got %0d,%0d,%0d exp 0,1,2", bus.wr_reg1, bus.wr_reg2, bus.wr_reg3); end
    n_cmp++; if (bus.wr_data3 !== 32'd102) begin n_bad++; $display("FAIL rr_data3 got %0d exp 102", bus.wr_data3); end
    n_cmp++; if (bus.pend_byte !== 32'h0000FFFF) begin n_bad++; $display("FAIL rr_pend_mix got %h exp 0000ffff", bus.pend_byte); end
    tick(); #1;
    n_cmp++; if ({bus.wr_en1, bus.wr_en2, bus.wr_en3} !== 3'b100) begin n_bad++; $display("FAIL rr_en_late got %b exp 100", {bus.wr_en1, bus.wr_en2, bus.wr_en3}); end
    n_cmp++; if ({bus.wr_reg1, bus.wr_data1} !== {3'd3, 32'd103}) begin n_bad++; $display("FAIL rr_late got %0d/%0d exp 3/103", bus.wr_reg1, bus.wr_data1); end
    n_cmp++; if (bus.pend_byte !== 32'h0000F000) begin n_bad++; $display("FAIL rr_pend_late got %h exp 0000f000", bus.pend_byte); end
    tick();
  endtask

  // rr_ptr enters at 0 (last grant was index 3).
  task automatic test_conflict();
    set_req(0, 3'd0, 4'h1, 32'hA0); set_req(1, 3'd0, 4'h1, 32'hA1);
    tick(); clr_req(); #1;
    n_cmp++; if (bus.pend_byte !== 32'h1) begin n_bad++; $display("FAIL cf_pend got %h exp 1", bus.pend_byte); end
    tick(); #1;
    n_cmp++; if ({bus.wr_en1, bus.wr_en2, bus.wr_data1} !== {2'b10, 32'hA0}) begin n_bad++; $display("FAIL cf_first got %b%b/%h exp 10/a0", bus.wr_en1, bus.wr_en2, bus.wr_data1); end
    tick(); #1;
    n_cmp++; if ({bus.wr_en1, bus.wr_en2, bus.wr_data1} !== {2'b10, 32'hA1}) begin n_bad++; $display("FAIL cf_second got %b%b/%h exp 10/a1", bus.wr_en1, bus.wr_en2, bus.wr_data1); end
    tick();
    // rr_ptr now 2: disjoint bytes of the same register go out together.
    set_req(0, 3'd0, 4'h1, 32'hB0); set_req(1, 3'd0, 4'h2, 32'hB1);
    tick(); clr_req(); #1;
    n_cmp++; if (bus.pend_byte !== 32'h3) begin n_bad++; $display("FAIL dj_pend got %h exp 3", bus.pend_byte); end
    tick(); #1;
    n_cmp++; if ({bus.wr_en1, bus.wr_en2, bus.wr_en3} !== 3'b110) begin n_bad++; $display("FAIL dj_en got %b exp 110", {bus.wr_en1, bus.wr_en2, bus.wr_en3}); end
    n_cmp++; if ({bus.wr_strb1, bus.wr_data1, bus.wr_strb2, bus.wr_data2} !== {4'h1, 32'hB0, 4'h2, 32'hB1})
      begin n_bad++; $display("FAIL dj_ports got %h/%h %h/%h exp 1/b0 2/b1", bus.wr_strb1, bus.wr_data1, bus.wr_strb2, bus.wr_data2); end
    tick();
    // rr_ptr now 1: on a conflict requester 1 now wins over requester 0.
    set_req(0, 3'd0, 4'hF, 32'hC0); set_req(1, 3'd0, 4'hF, 32'hC1);
    tick(); clr_req(); tick(); #1;
    n_cmp++; if ({bus.wr_en1, bus.wr_en2, bus.wr_data1} !== {2'b10, 32'hC1}) begin n_bad++; $display("FAIL rot_first got %b%b/%h exp 10/c1", bus.wr_en1, bus.wr_en2, bus.wr_data1); end
    tick(); #1;
    n_cmp++; if ({bus.wr_en1, bus.wr_data1} !== {1'b1, 32'hC0}) begin n_bad++; $display("FAIL rot_second got %b/%h exp 1/c0", bus.wr_en1, bus.wr_data1); end
    tick();
  endtask

  task automatic test_back_to_back();
    for (int j = 0; j < 8; j++) begin
      if (j >= 2 && j <= 6) begin
        n_cmp++; if ({bus.wr_en1, bus.wr_data1} !== {1'b1, 32'(j - 1)}) begin n_bad++; $display("FAIL b2b_stream%0d got %b/%0d exp 1/%0d", j, bus.wr_en1, bus.wr_data1, j - 1); end
      end else if (j == 7) begin
        n_cmp++; if (bus.wr_en1 !== 1'b0) begin n_bad++; $display("FAIL b2b_end got %b exp 0", bus.wr_en1); end
      end
      if (j < 5) begin
        set_req(2, 3'd5, 4'hF, 32'(j + 1));
        #1;
        n_cmp++; if (bus.req_ready[2] !== 1'b1) begin n_bad++; $display("FAIL b2b_ready%0d got %b exp 1", j, bus.req_ready[2]); end
      end else begin
        clr_req();
      end
      tick();
    end
  endtask

  task automatic test_flush();
    set_req(3, 3'd4, 4'hF, 32'hD3);
    tick(); clr_req();
    set_req(0, 3'd6, 4'hF, 32'hD0); set_req(1, 3'd7, 4'hF, 32'hD1);
    tick(); clr_req();
    flush = 1'b1;
    set_req(2, 3'd2, 4'hF, 32'hD2);
    #1;
    n_cmp++; if (bus.req_ready !== 4'b0) begin n_bad++; $display("FAIL fl_ready got %b exp 0000", bus.req_ready); end
    n_cmp++; if ({bus.wr_en1, bus.wr_reg1, bus.wr_data1} !== {1'b1, 3'd4, 32'hD3}) begin n_bad++; $display("FAIL fl_issued got %b/%0d/%h exp 1/4/d3", bus.wr_en1, bus.wr_reg1, bus.wr_data1); end
    n_cmp++; if (bus.pend_byte !== 32'hFF0F0000) begin n_bad++; $display("FAIL fl_pend got %h exp ff0f0000", bus.pend_byte); end
    tick(); flush = 1'b0; clr_req(); #1;
    n_cmp++; if ({bus.wr_en1, bus.wr_en2, bus.wr_en3} !== 3'b0) begin n_bad++; $display("FAIL fl_en got %b exp 000", {bus.wr_en1, bus.wr_en2, bus.wr_en3}); end
    n_cmp++; if (bus.pend_byte !== 32'h0) begin n_bad++; $display("FAIL fl_pend_after got %h exp 0", bus.pend_byte); end
    tick(); #1;
    n_cmp++; if ({bus.wr_en1, bus.wr_en2, bus.wr_en3} !== 3'b0) begin n_bad++; $display("FAIL fl_no_req2 got %b exp 000", {bus.wr_en1, bus.wr_en2, bus.wr_en3}); end
  endtask

  task automatic test_reset_mid();
    // Grant requester 1 alone so rr_ptr sits at 2 before the reset.
    set_req(1, 3'd0, 4'hF, 32'h11);
    tick(); clr_req(); tick(); tick();
    set_req(0, 3'd1, 4'hF, 32'hE0); set_req(1, 3'd2, 4'hF, 32'hE1); set_req(2, 3'd3, 4'hF, 32'hE2);
    tick(); clr_req();
    rst = 1'b1; #1;
    n_cmp++; if (bus.req_ready !== 4'b0) begin n_bad++; $display("FAIL rm_ready got %b exp 0000", bus.req_ready); end
    tick(); #1;
    n_cmp++; if ({bus.wr_en1, bus.wr_en2, bus.wr_en3} !== 3'b0) begin n_bad++; $display("FAIL rm_en got %b exp 000", {bus.wr_en1, bus.wr_en2, bus.wr_en3}); end
    n_cmp++; if (bus.pend_byte !== 32'h0) begin n_bad++; $display("FAIL rm_pend got %h exp 0", bus.pend_byte); end
    n_cmp++; if ({bus.wr_reg1, bus.wr_data1} !== 35'h0) begin n_bad++; $display("FAIL rm_port1 got %0d/%h exp 0/0", bus.wr_reg1, bus.wr_data1); end
    rst = 1'b0;
    // Conflicting pair on reg 1: rr_ptr=0 lets requester 0 go first.
    set_req(0, 3'd1, 4'hF, 32'hF0); set_req(3, 3'd1, 4'hF, 32'hF3);
    tick(); clr_req(); #1;
    n_cmp++; if (bus.wr_en1 !== 1'b0) begin n_bad++; $display("FAIL rm_dropped got %b exp 0", bus.wr_en1); end
    tick(); #1;
    n_cmp++; if ({bus.wr_en1, bus.wr_data1} !== {1'b1, 32'hF0}) begin n_bad++; $display("FAIL rm_rrptr got %b/%h exp 1/f0", bus.wr_en1, bus.wr_data1); end
    tick(); #1;
    n_cmp++; if ({bus.wr_en1, bus.wr_data1} !== {1'b1, 32'hF3}) begin n_bad++; $display("FAIL rm_next got %b/%h exp 1/f3", bus.wr_en1, bus.wr_data1); end
    tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_zero_strb();
    test_round_robin();
    test_conflict();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
